// File: rtl/hazard_ctrl_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks in-flight
// destinations, stalls on load-use, flushes on taken branches, registers EX forwarding selects.
module hazard_ctrl_unit #(
  parameter int NB_ADDR    = 5,
  parameter int N_STAGES   = 3,
  parameter int BRANCH_IDX = 1,
  parameter int NB_CNT     = 16,
  parameter int NB_SEL     = $clog2(N_STAGES)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_id_valid,
  input  logic [NB_ADDR-1:0] i_id_rs_addr,
  input  logic [NB_ADDR-1:0] i_id_rt_addr,
  input  logic               i_id_rs_used,
  input  logic               i_id_rt_used,
  input  logic               i_id_wr_enb,
  input  logic [NB_ADDR-1:0] i_id_wr_addr,
  input  logic               i_id_is_load,
  input  logic               i_branch_taken,
  output logic               o_stall,
  output logic               o_bubble,
  output logic               o_flush,
  output logic [NB_SEL-1:0]  o_fwd_rs_sel,
  output logic [NB_SEL-1:0]  o_fwd_rt_sel,
  output logic [NB_CNT-1:0]  o_stall_cnt,
  output logic [NB_CNT-1:0]  o_flush_cnt
);

  typedef struct packed {
    logic               valid;
    logic               wr_enb;
    logic               is_load;
    logic [NB_ADDR-1:0] addr;
  } entry_t;

  localparam entry_t ENTRY_RST = '{valid: 1'b0, wr_enb: 1'b0, is_load: 1'b0, addr: {NB_ADDR{1'b0}}};
  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

  entry_t            sb_q [N_STAGES];
  entry_t            sb_d [N_STAGES];
  logic [NB_SEL-1:0] rs_sel_q, rs_sel_d, rt_sel_q, rt_sel_d;
  logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              rs_hit0_s, rt_hit0_s, load_use_s, flush_s, stall_s;

  // r0 is hardwired zero, so a write to it never produces a forwardable value
  function automatic logic src_match(input entry_t e, input logic [NB_ADDR-1:0] src,
                                     input logic used);
    return e.valid & e.wr_enb & used & (e.addr == src) & (e.addr != {NB_ADDR{1'b0}});
  endfunction

  // Same-cycle hazard detection; a taken branch pre-empts any stall
  always_comb begin
    rs_hit0_s  = src_match(sb_q[0], i_id_rs_addr, i_id_rs_used);
    rt_hit0_s  = src_match(sb_q[0], i_id_rt_addr, i_id_rt_used);
    load_use_s = i_id_valid & sb_q[0].is_load & (rs_hit0_s | rt_hit0_s);
    flush_s    = i_enable & ~i_reset & i_branch_taken;
    stall_s    = i_enable & ~i_reset & load_use_s & ~flush_s;
  end

  assign o_stall  = stall_s;
  assign o_bubble = stall_s;
  assign o_flush  = flush_s;

  // Forwarding selects: scan oldest to youngest so the youngest producer wins
  always_comb begin
    rs_sel_d = {NB_SEL{1'b0}};
    rt_sel_d = {NB_SEL{1'b0}};
    if (i_id_valid && !load_use_s && !flush_s) begin
      for (int i = N_STAGES - 2; i >= 0; i--) begin
        rs_sel_d = src_match(sb_q[i], i_id_rs_addr, i_id_rs_used) ? NB_SEL'(i + 1) : rs_sel_d;
        rt_sel_d = src_match(sb_q[i], i_id_rt_addr, i_id_rt_used) ? NB_SEL'(i + 1) : rt_sel_d;
      end
    end else begin
      rs_sel_d = {NB_SEL{1'b0}};
      rt_sel_d = {NB_SEL{1'b0}};
    end
  end

  // Scoreboard shift; entries younger than the resolving branch are killed
  always_comb begin
    sb_d[0] = '{valid:   i_id_valid & ~load_use_s & ~flush_s,
                wr_enb:  i_id_wr_enb,
                is_load: i_id_is_load,
                addr:    i_id_wr_addr};
    for (int i = 1; i < N_STAGES; i++) begin
      sb_d[i] = sb_q[i-1];
      if (flush_s && ((i - 1) < BRANCH_IDX)) begin
        sb_d[i].valid = 1'b0;
      end else begin
        sb_d[i].valid = sb_q[i-1].valid;
      end
    end
  end

  // Saturating event counters
  always_comb begin
    stall_cnt_d = (stall_s && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + NB_CNT'(1) : stall_cnt_q;
    flush_cnt_d = (flush_s && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + NB_CNT'(1) : flush_cnt_q;
  end

  // State registers; reset wins over advance, and a disabled pipeline holds everything
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < N_STAGES; i++) begin
        sb_q[i] <= ENTRY_RST;
      end
      rs_sel_q    <= {NB_SEL{1'b0}};
      rt_sel_q    <= {NB_SEL{1'b0}};
      stall_cnt_q <= {NB_CNT{1'b0}};
      flush_cnt_q <= {NB_CNT{1'b0}};
    end else if (i_enable) begin
      for (int i = 0; i < N_STAGES; i++) begin
        sb_q[i] <= sb_d[i];
      end
      rs_sel_q    <= rs_sel_d;
      rt_sel_q    <= rt_sel_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end else begin
      rs_sel_q    <= rs_sel_q;
      rt_sel_q    <= rt_sel_q;
      stall_cnt_q <= stall_cnt_q;
      flush_cnt_q <= flush_cnt_q;
    end
  end

  assign o_fwd_rs_sel = rs_sel_q;
  assign o_fwd_rt_sel = rt_sel_q;
  assign o_stall_cnt  = stall_cnt_q;
  assign o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (N_STAGES=3, BRANCH_IDX=1, NB_CNT=2) with an
// expected-result queue checked against combinational and registered outputs.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst, en, v, rsu, rtu, we, ld, br;
  logic [4:0] rs, rt, wa;
  logic       stall, bubble, flush;
  logic [1:0] fwd_rs, fwd_rt, stall_cnt, flush_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic       st, bb, fl;
    logic [1:0] rs_sel, rt_sel, sc, fc;
    bit         comb;
  } exp_t;
  exp_t exp_q[$];

  hazard_ctrl_unit #(.NB_ADDR(5), .N_STAGES(3), .BRANCH_IDX(1), .NB_CNT(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_id_valid(v),
    .i_id_rs_addr(rs), .i_id_rt_addr(rt), .i_id_rs_used(rsu), .i_id_rt_used(rtu),
    .i_id_wr_enb(we), .i_id_wr_addr(wa), .i_id_is_load(ld), .i_branch_taken(br),
    .o_stall(stall), .o_bubble(bubble), .o_flush(flush),
    .o_fwd_rs_sel(fwd_rs), .o_fwd_rt_sel(fwd_rt),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    v = 1'b1; rs = s; rt = t; rsu = 1'b1; rtu = 1'b1;
    we = 1'b1; wa = d; ld = 1'b0; br = 1'b0;
  endtask

  task automatic lw(input logic [4:0] d, input logic [4:0] s);
    v = 1'b1; rs = s; rt = 5'd0; rsu = 1'b1; rtu = 1'b0;
    we = 1'b1; wa = d; ld = 1'b1; br = 1'b0;
  endtask

  // Inputs are already driven; check combinational lines now, registered ones after the edge
  task automatic apply(input string tag, input logic es, input logic eb, input logic ef,
                       input logic [1:0] ers, input logic [1:0] ert,
                       input logic [1:0] esc, input logic [1:0] efc, input bit cc);
    exp_t e;
    exp_q.push_back('{st: es, bb: eb, fl: ef, rs_sel: ers, rt_sel: ert, sc: esc, fc: efc, comb: cc});
    #1;
    e = exp_q.pop_front();
    if (e.comb) begin
      cmp({tag, "/stall"},  {7'd0, stall},  {7'd0, e.st});
      cmp({tag, "/bubble"}, {7'd0, bubble}, {7'd0, e.bb});
      cmp({tag, "/flush"},  {7'd0, flush},  {7'd0, e.fl});
    end
    @(posedge clk);
    #1;
    cmp({tag, "/rs_sel"},    {6'd0, fwd_rs},    {6'd0, e.rs_sel});
    cmp({tag, "/rt_sel"},    {6'd0, fwd_rt},    {6'd0, e.rt_sel});
    cmp({tag, "/stall_cnt"}, {6'd0, stall_cnt}, {6'd0, e.sc});
    cmp({tag, "/flush_cnt"}, {6'd0, flush_cnt}, {6'd0, e.fc});
    vectors++;
  endtask

  initial begin
    int sc;
    rst = 1'b1; en = 1'b1;
    alu(5'd1, 5'd20, 5'd21); v = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    apply("reset", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

    // independent ALU ops: nothing to forward
    for (int k = 1; k <= 5; k++) begin
      alu(5'(k), 5'd20, 5'd21);
      apply("indep", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    end

    // forwarding distances; oldest entry (r3) not forwarded
    alu(5'd6, 5'd3, 5'd4);    apply("fwd_far",   1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b1);
    alu(5'd7, 5'd6, 5'd21);   apply("fwd_1",     1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1);
    alu(5'd8, 5'd22, 5'd23);  apply("unrel",     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    alu(5'd9, 5'd7, 5'd20);   apply("fwd_2",     1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1);
    alu(5'd12, 5'd20, 5'd21); apply("w12a",      1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    alu(5'd12, 5'd9, 5'd20);  apply("w12b",      1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b1);
    alu(5'd13, 5'd20, 5'd12); apply("youngest",  1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1);
    alu(5'd14, 5'd13, 5'd12); rsu = 1'b0;
    apply("unused_rs", 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b1);

    // load-use: one stall cycle, then forward from stage 2
    lw(5'd5, 5'd20);          apply("lw5",       1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    alu(5'd15, 5'd20, 5'd5);  apply("lu_stall",  1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);
    apply("lu_fwd", 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 2'd0, 1'b1);

    // r0 is never a hazard or forwarding source
    lw(5'd0, 5'd20);          apply("lw_r0",     1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);
    alu(5'd0, 5'd0, 5'd0);    apply("rd_r0a",    1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);
    alu(5'd16, 5'd0, 5'd0);   apply("rd_r0b",    1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);

    // invalid ID instruction: no stall even against a load
    lw(5'd17, 5'd20);         apply("lw17",      1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);
    alu(5'd16, 5'd20, 5'd17); v = 1'b0;
    apply("id_inval", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);

    // taken branch with a load-use hazard in ID: flush wins
    lw(5'd18, 5'd20);         apply("lw18",      1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1);
    alu(5'd28, 5'd18, 5'd21); br = 1'b1;
    apply("br_flush", 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 2'd1, 1'b1);
    alu(5'd19, 5'd18, 5'd21); apply("post_br",   1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 2'd1, 1'b1);

    // disabled pipeline freezes selects, scoreboard and counters
    alu(5'd24, 5'd19, 5'd21); apply("pre_hold",  1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1, 1'b1);
    en = 1'b0; alu(5'd25, 5'd20, 5'd21); br = 1'b1;
    apply("disabled", 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd1, 2'd1, 1'b1);
    en = 1'b1;
    alu(5'd29, 5'd21, 5'd24); apply("post_hold", 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd1, 1'b1);

    // four more load-use stalls: 2-bit counter saturates at 3
    sc = 1;
    for (int k = 0; k < 4; k++) begin
      lw(5'd26, 5'd20);
      apply("sat_lw", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'(sc), 2'd1, 1'b1);
      sc = (sc == 3) ? 3 : sc + 1;
      alu(5'd27, 5'd26, 5'd21);
      apply("sat_stall", 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'(sc), 2'd1, 1'b1);
      apply("sat_fwd",   1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'(sc), 2'd1, 1'b1);
    end

    // reset mid-operation beats advance and flush
    rst = 1'b1; alu(5'd30, 5'd20, 5'd21); br = 1'b1;
    apply("mid_reset", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    rst = 1'b0;
    alu(5'd31, 5'd27, 5'd30); apply("post_rst",  1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
